mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-side responder to the datapath's load/store outputs (ALU result as address, store data, access size).
- Turns each core load/store into a single-outstanding request/acknowledge transaction on a word-wide data-memory bus, with byte enables.
- Stalls the core until the memory acknowledges, then returns load data right-justified. Sign/zero extension stays in the datapath, which uses its load-signed control.

Parameters:
- TIMEOUT, 16, cycles waiting for i_memAck before abandoning the access (minimum 1).

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_memRead  input  1  core requests a load this cycle
- i_memWrite  input  1  core requests a store this cycle
- i_memSize  input  2  00 byte, 01 half, 10 word, 11 reserved
- i_addr  input  32  byte address (datapath ALU result)
- i_writeData  input  32  store data, right-justified
- o_readData  output  32  load data, right-justified, unextended
- o_stall  output  1  core must hold PC and pipeline state
- o_misaligned  output  1  access-fault indication, combinational
- o_busErr  output  1  one-cycle pulse on timeout
- o_memReq  output  1  bus request
- o_memWe  output  1  bus write enable
- o_memAddr  output  32  word address, bits [1:0] = 00
- o_memBe  output  4  byte enables
- o_memWdata  output  32  lane-shifted store data
- i_memAck  input  1  bus acknowledge
- i_memRdata  input  32  bus read word, valid with i_memAck

Behaviour:
- Clock is i_clk. Reset is i_reset, synchronous, active-high. Everything in this block is on i_clk.
- Reset values:
  - state IDLE
  - o_memReq 0, o_memWe 0, o_memAddr 0, o_memBe 0, o_memWdata 0
  - o_readData 0, o_busErr 0
  - timeout counter 0
- Access validity (combinational):
  - o_misaligned = (i_memRead | i_memWrite) & (size==01 & addr[0] | size==10 & addr[1:0]!=0 | size==11).
  - A misaligned or reserved access issues no bus request and does not stall.
- i_memRead & i_memWrite both set: the write wins and the read is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - o_stall = valid access present (combinational).
  - On a valid access, at the next edge:
    - latch o_memAddr = {addr[31:2],2'b00}, o_memWe = write, o_memBe, o_memWdata;
    - latch offset = addr[1:0] and size;
    - set o_memReq = 1; go to REQ.
- Byte enables:
  - byte: 1 << off
  - half: 0011 << off
  - word: 1111
- Store data: o_memWdata = i_writeData << (8*off). For half and word, only the in-lane bytes are meaningful.
- REQ:
  - o_stall = 1.
  - All o_mem* outputs are held stable until ack.
  - Counter increments each cycle.
  - On i_memAck (including in the first REQ cycle):
    - for a read, o_readData = (i_memRdata >> 8*off) masked to the size: byte 0xFF, half 0xFFFF, word all;
    - for a write, o_readData = 0;
    - drop o_memReq; clear counter; go to DONE.
  - When the counter reaches TIMEOUT-1 without ack:
    - drop o_memReq; o_readData = 0; o_busErr = 1 for one cycle; go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - o_stall = 0; o_readData is valid for the datapath write-back.
  - Go to IDLE at the next edge; o_busErr clears.
  - A new access is never accepted in DONE. This prevents re-issuing the same instruction while the core advances.
- Throughput: at most one access per 3 cycles. With a same-cycle ack, a load costs 2 stall cycles plus the DONE cycle.
- o_readData holds its value in IDLE until the next completion.
- Reset mid-REQ: drop o_memReq immediately at the edge and return to IDLE. A late i_memAck received in IDLE is ignored.
- i_memAck outside REQ is ignored.

Decomposition:
- Shared package (mem_pkg):
  - size encodings MEM_B/MEM_H/MEM_W/MEM_RSV;
  - state enum IDLE/REQ/DONE;
  - byte-enable mask constants.
- One natural sub-module: mem_lane_align. It is combinational and produces the store shift and byte enables from size and offset, plus load extraction from offset and size. It is shared so it can be unit-tested alone.

Test Plan:
- Word load, addr 0x100, bus acks in the first REQ cycle with rdata 0xDEADBEEF:
  - memAddr 0x100, Be 1111, We 0;
  - stall high 2 cycles, then DONE readData 0xDEADBEEF.
- Byte store, addr 0x103, writeData 0x000000A5:
  - Be 1000, Wdata 0xA5000000, We 1;
  - readData 0 in DONE.
- Half load, addr 0x202, rdata 0x1234ABCD, ack after 3 wait cycles:
  - readData 0x00001234;
  - stall held for the full wait;
  - req and addr stable throughout.
- Misaligned half at 0x201 and word at 0x102:
  - o_misaligned = 1, memReq never asserts, stall stays 0.
- TIMEOUT=4, no ack:
  - memReq drops after 4 REQ cycles;
  - busErr pulses for exactly 1 cycle; readData 0; stall releases in DONE.
- Reset asserted in the second REQ cycle:
  - next cycle memReq 0, state IDLE;
  - a later stray ack produces no DONE and no readData change.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access unit:
// access sizes, FSM states, lane masks.
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        MEM_B   = 2'b00,
        MEM_H   = 2'b01,
        MEM_W   = 2'b10,
        MEM_RSV = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mau_state_e;

    localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    localparam logic [XLEN-1:0] LD_MASK_B = 32'h0000_00FF;
    localparam logic [XLEN-1:0] LD_MASK_H = 32'h0000_FFFF;
    localparam logic [XLEN-1:0] LD_MASK_W = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide request/acknowledge data-memory bus with byte enables.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic            o_memReq;
    logic            o_memWe;
    logic [XLEN-1:0] o_memAddr;
    logic [BE_W-1:0] o_memBe;
    logic [XLEN-1:0] o_memWdata;
    logic            i_memAck;
    logic [XLEN-1:0] i_memRdata;

    modport master (
        output o_memReq, o_memWe, o_memAddr, o_memBe, o_memWdata,
        input  i_memAck, i_memRdata
    );

    modport slave (
        input  o_memReq, o_memWe, o_memAddr, o_memBe, o_memWdata,
        output i_memAck, i_memRdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store shift and byte enables from size/offset,
// load extraction (right-justified, unextended) from offset/size.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_e       st_size,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [BE_W-1:0] st_be,
    output logic [XLEN-1:0] st_wdata,
    input  mem_size_e       ld_size,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] ld_mask;

    always_comb begin
        st_be = BE_NONE;
        case (st_size)
            MEM_B:   st_be = BE_BYTE << st_off;
            MEM_H:   st_be = BE_HALF << st_off;
            MEM_W:   st_be = BE_WORD;
            default: st_be = BE_NONE;
        endcase
        st_wdata = st_data << {st_off, 3'b000};
    end

    always_comb begin
        ld_mask = LD_MASK_W;
        case (ld_size)
            MEM_B:   ld_mask = LD_MASK_B;
            MEM_H:   ld_mask = LD_MASK_H;
            default: ld_mask = LD_MASK_W;
        endcase
        ld_data = (ld_word >> {ld_off, 3'b000}) & ld_mask;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store responder: turns core accesses into bus
// transactions, stalls until ack or timeout, returns right-justified load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_memRead,
    input  logic             i_memWrite,
    input  logic [1:0]       i_memSize,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_writeData,
    output logic [XLEN-1:0]  o_readData,
    output logic             o_stall,
    output logic             o_misaligned,
    output logic             o_busErr,
    mem_access_unit_if.master mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mau_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      off_q, off_d;
    mem_size_e       size_q, size_d;

    mem_size_e       size_in;
    logic            access;
    logic            bad_align;
    logic            valid_acc;
    logic [BE_W-1:0] st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    mem_lane_align u_lane_align (
        .st_size  (size_in),
        .st_off   (i_addr[1:0]),
        .st_data  (i_writeData),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_word  (mem.i_memRdata),
        .ld_data  (ld_data)
    );

    // Access validity; a misaligned or reserved access never reaches the bus.
    always_comb begin
        size_in      = mem_size_e'(i_memSize);
        access       = i_memRead | i_memWrite;
        bad_align    = ((size_in == MEM_H) & i_addr[0])
                     | ((size_in == MEM_W) & (i_addr[1:0] != 2'b00))
                     | (size_in == MEM_RSV);
        o_misaligned = access & bad_align;
        valid_acc    = access & ~bad_align;
    end

    // Next-state and registered-output logic; write wins when both requested.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        cnt_d     = cnt_q;
        off_d     = off_q;
        size_d    = size_q;
        o_stall   = 1'b0;

        case (state_q)
            IDLE: begin
                o_stall = valid_acc;
                if (valid_acc) begin
                    addr_d  = {i_addr[XLEN-1:2], 2'b00};
                    we_d    = i_memWrite;
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    off_d   = i_addr[1:0];
                    size_d  = size_in;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (mem.i_memAck) begin
                    rdata_d = we_q ? '0 : ld_data;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Never accept here: the core is still presenting the finished instruction.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= MEM_B;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            size_q    <= size_d;
        end
    end

    assign mem.o_memReq   = req_q;
    assign mem.o_memWe    = we_q;
    assign mem.o_memAddr  = addr_q;
    assign mem.o_memBe    = be_q;
    assign mem.o_memWdata = wdata_q;
    assign o_readData     = rdata_q;
    assign o_busErr       = bus_err_q;

endmodule
